// File: rtl/pcw_vram_responder.sv
// ---------------------------------------------------------------------------
// pcw_vram_responder
//
// Shares one single-port byte RAM between the video controller and the CPU
// using a fixed four-slot schedule locked to the pixel strobe.
//
//   phase 1 : video slot, vid_addr is loaded onto ram_addr
//   phase 2 : video data is captured into vid_din; the only CPU issue slot
//   phase 3 : (cycle after a CPU issue) read data / ack are captured
//   phase 0 : idle
//
// Addresses registered at the end of a slot reach the RAM in the next cycle,
// and the RAM returns data one cycle later. That data is captured at the
// end of the following slot. The video path therefore has a fixed latency.
// The worst-case CPU request-to-ack latency is 5 clk_sys cycles.
//
// Ports:
//   clk_sys    in   64 MHz system clock (rising edge)
//   reset_n    in   asynchronous active-low reset
//   ce_pix     in   pixel strobe, forces the next phase to 1
//   vid_addr   in   video read address (17 bits)
//   vid_din    out  registered video read data
//   cpu_addr   in   CPU address (RAM_AW bits)
//   cpu_rd     in   CPU read request level
//   cpu_wr     in   CPU write request level (wins over cpu_rd)
//   cpu_dout   in   CPU write data
//   cpu_din    out  registered CPU read data
//   cpu_ack    out  one-cycle completion pulse
//   ram_addr   out  registered RAM address
//   ram_we     out  registered RAM write enable
//   ram_wdata  out  registered RAM write data
//   ram_rdata  in   RAM read data, valid one cycle after ram_addr
// ---------------------------------------------------------------------------
module pcw_vram_responder #(
  parameter int RAM_AW = 18
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic [16:0]       vid_addr,
  output logic [7:0]        vid_din,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_din,
  output logic              cpu_ack,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_VID  = 2'd1;
  localparam logic [1:0] PH_CPU  = 2'd2;
  localparam logic [1:0] PH_DONE = 2'd3;

  logic [1:0]        phase_r;
  logic [1:0]        phase_nxt_s;
  logic              armed_r;
  logic              pend_r;
  logic              pend_rd_r;
  logic              cpu_req_s;
  logic              issue_s;
  logic [RAM_AW-1:0] vid_addr_ext_s;
  logic [7:0]        vid_din_r;
  logic [7:0]        cpu_din_r;
  logic              cpu_ack_r;
  logic [RAM_AW-1:0] ram_addr_r;
  logic              ram_we_r;
  logic [7:0]        ram_wdata_r;

  assign vid_addr_ext_s = RAM_AW'(vid_addr);

  assign vid_din   = vid_din_r;
  assign cpu_din   = cpu_din_r;
  assign cpu_ack   = cpu_ack_r;
  assign ram_addr  = ram_addr_r;
  assign ram_we    = ram_we_r;
  assign ram_wdata = ram_wdata_r;

  // Next slot phase: the strobe re-aligns, otherwise free-run modulo 4.
  always_comb begin
    phase_nxt_s = phase_r;
    if (ce_pix) begin
      phase_nxt_s = PH_VID;
    end else begin
      phase_nxt_s = phase_r + 2'd1;
    end
  end

  // CPU issue decision: only in phase 2, and only once per request level.
  always_comb begin
    cpu_req_s = cpu_rd | cpu_wr;
    issue_s   = 1'b0;
    if ((phase_r == PH_CPU) && cpu_req_s && armed_r) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Slot phase register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      phase_r <= PH_IDLE;
    end else begin
      phase_r <= phase_nxt_s;
    end
  end

  // Arming: cleared on issue, re-armed only after a cycle with no request.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      armed_r <= 1'b1;
    end else if (issue_s) begin
      armed_r <= 1'b0;
    end else if (!cpu_req_s) begin
      armed_r <= 1'b1;
    end else begin
      armed_r <= armed_r;
    end
  end

  // In-flight CPU access marker. The result always lands in the cycle right
  // after the issue, even if ce_pix shortened the period.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend_r    <= 1'b0;
      pend_rd_r <= 1'b0;
    end else begin
      pend_r    <= issue_s;
      pend_rd_r <= issue_s & ~cpu_wr;
    end
  end

  // RAM port: video address in phase 1, CPU address on issue, else hold.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr_r  <= '0;
      ram_we_r    <= 1'b0;
      ram_wdata_r <= 8'h00;
    end else begin
      ram_we_r <= issue_s & cpu_wr;
      case (phase_r)
        PH_VID: begin
          ram_addr_r <= vid_addr_ext_s;
        end
        PH_CPU: begin
          if (issue_s) begin
            ram_addr_r  <= cpu_addr;
            ram_wdata_r <= cpu_dout;
          end
        end
        default: begin
          ram_addr_r <= ram_addr_r;
        end
      endcase
    end
  end

  // Video data capture at the end of phase 2; held otherwise.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vid_din_r <= 8'h00;
    end else if (phase_r == PH_CPU) begin
      vid_din_r <= ram_rdata;
    end else begin
      vid_din_r <= vid_din_r;
    end
  end

  // CPU completion: ack for every access, read data for reads only.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_ack_r <= 1'b0;
      cpu_din_r <= 8'h00;
    end else begin
      cpu_ack_r <= pend_r;
      if (pend_rd_r) begin
        cpu_din_r <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_pcw_vram_responder.sv
// ---------------------------------------------------------------------------
// tb_pcw_vram_responder
//
// Self-checking bench for pcw_vram_responder. It uses an asynchronous-read
// RAM model whose unwritten locations read as (addr[7:0] ^ 0x5A). Location
// 0x01234 is preset to 0xA5. ce_pix fires when ce_cnt wraps to 0, so while
// the DUT is aligned its phase equals ce_cnt.
// ---------------------------------------------------------------------------
module tb_pcw_vram_responder;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [17:0] addr;
    logic [7:0]  wdata;
    int          start;
    logic [7:0]  exp_din;
  } vec_t;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ce_pix;
  logic [16:0] vid_addr;
  logic [7:0]  vid_din;
  logic [17:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_ack;
  logic [17:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int checks = 0;
  int errors = 0;
  int ce_cnt = 0;
  bit ce_en = 1'b1;
  int we_in_p1 = 0;

  logic [7:0] wmem   [0:262143];
  bit         wvalid [0:262143];

  pcw_vram_responder #(.RAM_AW(18)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
    .vid_addr(vid_addr), .vid_din(vid_din),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_ack(cpu_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #8 clk_sys = ~clk_sys;

  function automatic logic [7:0] pat(input logic [17:0] a);
    if (a == 18'h01234) return 8'hA5;
    return a[7:0] ^ 8'h5A;
  endfunction

  assign ram_rdata = wvalid[ram_addr] ? wmem[ram_addr] : pat(ram_addr);

  always @(posedge clk_sys) begin
    if (ram_we) begin
      wmem[ram_addr]   <= ram_wdata;
      wvalid[ram_addr] <= 1'b1;
    end
  end

  // Pixel strobe generator.
  initial begin
    ce_pix = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      ce_cnt = (ce_cnt + 1) % 4;
      ce_pix = ce_en && (ce_cnt == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cnt(input int c);
    int n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (ce_cnt != c && n < 16);
  endtask

  task automatic step();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic cpu_op(input vec_t v);
    int lat = 0;
    int we_cnt = 0;
    bit got = 1'b0;
    int exp_lat = ((6 - v.start) % 4) + 2;
    int n = 0;
    do begin
      step();
      n++;
    end while (ce_cnt != v.start && n < 16);
    cpu_addr = v.addr;
    cpu_dout = v.wdata;
    cpu_rd   = v.rd;
    cpu_wr   = v.wr;
    while (!got && lat < 10) begin
      @(negedge clk_sys);
      if (ram_we) begin
        we_cnt++;
        if (ce_cnt == 1) we_in_p1++;
      end
      if (cpu_ack) begin
        got = 1'b1;
      end else begin
        step();
        lat++;
      end
    end
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    chk("ack_seen", 32'(got), 1);
    chk("ack_latency", lat, exp_lat);
    chk("we_pulses", we_cnt, 32'(v.wr));
    if (!v.wr) chk("cpu_din", 32'(cpu_din), 32'(v.exp_din));
  endtask

  task automatic count_acks(input int cycles, output int acks, output logic [7:0] din);
    acks = 0;
    din = 8'h00;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_sys);
      if (cpu_ack) begin
        acks++;
        din = cpu_din;
      end
    end
  endtask

  vec_t vecs[10];
  vec_t vc;
  int   acks;
  logic [7:0] din;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 18'h20010, 8'h3C, 2, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 18'h20010, 8'h00, 1, 8'h3C};
    vecs[2] = '{1'b0, 1'b1, 18'h00007, 8'hC3, 3, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 18'h00007, 8'h00, 0, 8'hC3};
    vecs[4] = '{1'b1, 1'b0, 18'h00100, 8'h00, 1, 8'h5A};
    vecs[5] = '{1'b1, 1'b0, 18'h3FFFF, 8'h00, 2, 8'hA5};
    vecs[6] = '{1'b0, 1'b1, 18'h3FFFF, 8'h11, 0, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 18'h3FFFF, 8'h00, 3, 8'h11};
    vecs[8] = '{1'b1, 1'b1, 18'h00200, 8'h77, 1, 8'h00};
    vecs[9] = '{1'b1, 1'b0, 18'h00200, 8'h00, 2, 8'h77};

    reset_n  = 1'b0;
    vid_addr = 17'h01234;
    cpu_addr = 18'h0;
    cpu_rd   = 1'b0;
    cpu_wr   = 1'b0;
    cpu_dout = 8'h00;

    // Reset state.
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_vid_din", 32'(vid_din), 0);
    chk("rst_cpu_din", 32'(cpu_din), 0);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    step();
    reset_n = 1'b1;
    repeat (8) step();

    // Video read path.
    wait_cnt(2);
    chk("vid_ram_addr", 32'(ram_addr), 32'h01234);
    wait_cnt(0);
    chk("vid_din", 32'(vid_din), 32'hA5);

    // Table-driven CPU accesses.
    for (int i = 0; i < 10; i++) cpu_op(vecs[i]);
    chk("vid_din_kept", 32'(vid_din), 32'hA5);

    // Contention: CPU read in phase 1 with vid_addr 0x00100.
    do step(); while (ce_cnt != 1);
    vid_addr = 17'h00100;
    vc = '{1'b1, 1'b0, 18'h20010, 8'h00, 1, 8'h3C};
    cpu_op(vc);
    chk("contention_vid_din", 32'(vid_din), 32'h5A);
    do step(); while (ce_cnt != 1);
    vid_addr = 17'h01234;

    // Held request: one access only, re-arm after a one-cycle drop.
    do step(); while (ce_cnt != 2);
    cpu_addr = 18'h00100;
    cpu_rd = 1'b1;
    count_acks(25, acks, din);
    chk("held_acks", acks, 1);
    step();
    cpu_rd = 1'b0;
    step();
    cpu_rd = 1'b1;
    count_acks(8, acks, din);
    chk("rearm_acks", acks, 1);
    cpu_rd = 1'b0;

    // Request dropped before phase 2.
    do step(); while (ce_cnt != 0);
    cpu_rd = 1'b1;
    step();
    cpu_rd = 1'b0;
    count_acks(8, acks, din);
    chk("dropped_acks", acks, 0);

    // Write dropped during phase 3 still completes.
    do step(); while (ce_cnt != 2);
    cpu_addr = 18'h00300;
    cpu_dout = 8'h9E;
    cpu_wr = 1'b1;
    step();
    cpu_wr = 1'b0;
    count_acks(4, acks, din);
    chk("late_drop_acks", acks, 1);
    vc = '{1'b1, 1'b0, 18'h00300, 8'h00, 1, 8'h9E};
    cpu_op(vc);

    // Reset in phase 3 of a CPU read.
    do step(); while (ce_cnt != 2);
    cpu_addr = 18'h00100;
    cpu_rd = 1'b1;
    step();
    reset_n = 1'b0;
    @(negedge clk_sys);
    chk("midrst_ack", 32'(cpu_ack), 0);
    chk("midrst_outs", 32'({vid_din, cpu_din, ram_we, ram_wdata}), 0);
    chk("midrst_addr", 32'(ram_addr), 0);
    step();
    step();
    reset_n = 1'b1;
    count_acks(12, acks, din);
    chk("postrst_acks", acks, 1);
    chk("postrst_din", 32'(din), 32'h5A);
    cpu_rd = 1'b0;
    wait_cnt(0);
    wait_cnt(0);
    chk("postrst_vid_din", 32'(vid_din), 32'hA5);

    // Missing ce_pix: free-running phase keeps serving the CPU.
    ce_en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      vc = '{1'b1, 1'b0, 18'h00100, 8'h00, s, 8'h5A};
      cpu_op(vc);
    end
    chk("no_x", 32'($isunknown({vid_din, cpu_din, cpu_ack, ram_addr, ram_we, ram_wdata})), 0);
    ce_en = 1'b1;

    chk("we_in_phase1", we_in_p1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcw_vram_responder.md
PCW_VRAM_RESPONDER -- requirements
Module: pcw_vram_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 18, meaning backing-RAM address width in bits.
REQ-002 SHALL have port clk_sys  in  1  64 MHz system clock; all state clocked on its rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port ce_pix  in  1  one-cycle pixel strobe from the video controller, every 4 clk_sys cycles.
REQ-005 SHALL have port vid_addr  in  17  video read address; stable from the cycle after ce_pix.
REQ-006 SHALL have port vid_din  out  8  registered video read data returned to the video controller.
REQ-007 SHALL have port cpu_addr  in  RAM_AW  CPU access address.
REQ-008 SHALL have port cpu_rd / cpu_wr  in  1 each  CPU read / write request levels.
REQ-009 SHALL have port cpu_dout  in  8  CPU write data.
REQ-010 SHALL have port cpu_din  out  8  registered CPU read data.
REQ-011 SHALL have port cpu_ack  out  1  one-cycle completion pulse.
REQ-012 SHALL have port ram_addr  out  RAM_AW  registered RAM address.
REQ-013 SHALL have port ram_we  out  1  registered RAM write enable.
REQ-014 SHALL have port ram_wdata  out  8  registered RAM write data.
REQ-015 SHALL have port ram_rdata  in  8  RAM read data, valid exactly 1 cycle after ram_addr is presented.

Function
REQ-016 SHALL keep a 2-bit slot phase: ce_pix=1 forces next phase to 1; otherwise phase increments modulo 4.
REQ-017 SHALL tolerate missing ce_pix by free-running the phase (0..3 wrap), with no lockup.
REQ-018 SHALL, in phase 1, drive ram_addr={zero-extend vid_addr} and ram_we=0 (video slot; never yielded to the CPU).
REQ-019 SHALL, in phase 2, capture ram_rdata into vid_din; vid_din is held constant at every other time.
REQ-020 SHALL therefore return video data with fixed latency: address sampled phase 1, vid_din updated at the end of phase 2, valid at the next ce_pix.
REQ-021 SHALL, in phase 2, issue a CPU access if (cpu_rd|cpu_wr)=1 and the armed flag=1; phase 2 is the only CPU issue slot.
REQ-022 SHALL, on a CPU issue, drive ram_addr=cpu_addr and ram_wdata=cpu_dout, with ram_we=cpu_wr; cpu_wr=cpu_rd=1 is treated as a write.
REQ-023 SHALL, in phase 3 after a CPU issue, capture ram_rdata into cpu_din on reads only, and pulse cpu_ack=1 for that single cycle for reads and writes.
REQ-024 SHALL clear the armed flag on issue and re-set it only after a cycle with cpu_rd=cpu_wr=0, so each request level produces exactly one access.
REQ-025 SHALL, in phases 0 and 3 and in phase 2 without an issue, drive ram_we=0 and hold ram_addr at its previous value.
REQ-026 SHALL ignore a CPU request dropped before phase 2: no access, no ack.
REQ-027 SHALL complete an issued access even if the request drops during phase 3: the ack still pulses and the write is already committed.
REQ-028 SHALL ensure ram_we is never asserted in phase 1 and is high for at most one cycle per issue.
REQ-029 SHALL bound the worst-case CPU latency from request assertion to cpu_ack at 5 clk_sys cycles.

Reset
REQ-030 SHALL, while reset_n=0, hold phase=0, armed=1, vid_din=0, cpu_din=0, cpu_ack=0, ram_addr=0, ram_we=0, ram_wdata=0.
REQ-031 SHALL abandon any in-flight access on reset mid-operation: no ack after release, and the first access follows the first post-release phase 2.
REQ-032 SHALL resume normal slot alignment at the first ce_pix after reset_n deasserts.

Verification
REQ-033 Video read: RAM[0x01234]=0xA5, vid_addr=0x01234 held, ce_pix every 4 cycles -> ram_addr=0x01234 in phase 1; vid_din=0xA5 at the next ce_pix.
REQ-034 CPU write then read: cpu_wr, addr 0x20010, data 0x3C -> single ram_we pulse in phase 2, cpu_ack in phase 3; then cpu_rd same addr -> cpu_din=0x3C with ack; vid_din unchanged throughout.
REQ-035 Held request: cpu_rd held 20 cycles after ack -> exactly one RAM access and one ack; drop 1 cycle then reassert -> a second access.
REQ-036 Contention: cpu_rd asserted in phase 1 while vid_addr=0x00100 -> video read unaffected, CPU issued in the same period's phase 2, ack in 2 cycles.
REQ-037 Reset mid-op: reset_n low in phase 3 of a CPU read -> cpu_ack=0 and all outputs 0; after release with cpu_rd still high -> one access, one ack.
REQ-038 Missing ce_pix: ce_pix held low 40 cycles -> phase wraps 0..3, CPU requests still acked within 5 cycles, no X on outputs.
